// File: rtl/fu_pkg.sv
// fu_alu shared definitions: opcodes, flag bit positions, FSM states.
package fu_pkg;

  localparam int MULCYCLES_DEF = 8;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_SHL  = 8'h05;
  localparam logic [7:0] OP_SHR  = 8'h06;
  localparam logic [7:0] OP_MUL  = 8'h07;
  localparam logic [7:0] OP_PASS = 8'h08;

  localparam int FZ   = 0;
  localparam int FC   = 1;
  localparam int FN   = 2;
  localparam int FV   = 3;
  localparam int FILL = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: result and flags for every opcode
// except MUL, which the iterative datapath in fu_alu handles.
module alu_core
  import fu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [7:0] op,
  output logic [7:0] result,
  output logic [7:0] flags
);

  logic [8:0] sum;
  logic [8:0] diff;
  logic       c;
  logic       v;
  logic       ill;

  assign sum  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {8'b0, cin};

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    ill    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[7:0];
        c      = sum[8];
        v      = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      OP_SUB: begin
        result = diff[7:0];
        c      = diff[8];
        v      = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[2:0];
      OP_SHR:  result = a >> b[2:0];
      OP_MUL:  result = '0;
      OP_PASS: result = a;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    flags       = '0;
    flags[FZ]   = (result == 8'h00);
    flags[FC]   = c;
    flags[FN]   = result[7];
    flags[FV]   = v;
    flags[FILL] = ill;
  end

endmodule

// File: rtl/fu_alu.sv
// Integer execution unit: captures a station release, runs single-cycle
// ops or an iterative shift-add MUL, and holds the result on the CDB.
module fu_alu
  import fu_pkg::*;
#(
  parameter int MULCYCLES = MULCYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issuevalid,
  input  logic [7:0]      operand,
  input  logic [7:0]      wbs,
  input  logic [1:0][7:0] depvals,
  input  logic [7:0]      flag,
  input  logic [7:0]      robid,
  output logic            busy,
  output logic            cdbreq,
  input  logic            cdbgrant,
  output logic [3:0]      cdbtag,
  output logic [7:0]      cdbval,
  output logic [7:0]      cdbflag,
  output logic [7:0]      cdbwbs,
  output logic [7:0]      cdbrobid,
  output logic            issueerr
);

  localparam int CW = $clog2(MULCYCLES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   acc;
  logic [15:0]   mcand;
  logic [7:0]    mplier;
  logic [7:0]    res;
  logic [7:0]    flg;
  logic [7:0]    wbs_q;
  logic [7:0]    rid_q;
  logic          err;

  logic [7:0]    alu_res;
  logic [7:0]    alu_flg;
  logic [15:0]   acc_next;
  logic [7:0]    mul_flg;
  logic          flag_unused;

  // only the carry-in bit of the issue flags is meaningful
  assign flag_unused = ^flag[7:1];

  alu_core u_core (
    .a      (depvals[0]),
    .b      (depvals[1]),
    .cin    (flag[0]),
    .op     (operand),
    .result (alu_res),
    .flags  (alu_flg)
  );

  assign acc_next = acc + (mplier[0] ? mcand : 16'h0000);

  always_comb begin
    mul_flg     = '0;
    mul_flg[FZ] = (acc_next[7:0] == 8'h00);
    mul_flg[FC] = |acc_next[15:8];
    mul_flg[FN] = acc_next[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      res    <= '0;
      flg    <= '0;
      wbs_q  <= '0;
      rid_q  <= '0;
      err    <= 1'b0;
    end else begin
      if (issuevalid && state != ST_IDLE)
        err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (issuevalid) begin
            wbs_q <= wbs;
            rid_q <= robid;
            if (operand == OP_MUL) begin
              state  <= ST_EXEC;
              cnt    <= CW'(MULCYCLES);
              acc    <= '0;
              mcand  <= {8'h00, depvals[0]};
              mplier <= depvals[1];
            end else begin
              res   <= alu_res;
              flg   <= alu_flg;
              state <= ST_WB;
            end
          end
        end
        ST_EXEC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res   <= acc_next[7:0];
            flg   <= mul_flg;
            state <= ST_WB;
          end
        end
        ST_WB: begin
          if (cdbgrant)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // releasing on grant lets the next station issue into an IDLE unit
  assign busy     = (state != ST_IDLE) && !(state == ST_WB && cdbgrant);
  assign cdbreq   = (state == ST_WB);
  assign cdbtag   = cdbreq ? rid_q[3:0] : 4'h0;
  assign cdbval   = cdbreq ? res : 8'h00;
  assign cdbflag  = cdbreq ? flg : 8'h00;
  assign cdbwbs   = cdbreq ? wbs_q : 8'h00;
  assign cdbrobid = cdbreq ? rid_q : 8'h00;
  assign issueerr = err;

endmodule

// File: tb/tb_fu_alu.sv
// Self-checking bench for fu_alu: vector table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_fu_alu;

  logic            clk = 1'b0;
  logic            rst;
  logic            issuevalid;
  logic [7:0]      operand;
  logic [7:0]      wbs;
  logic [1:0][7:0] depvals;
  logic [7:0]      flag;
  logic [7:0]      robid;
  logic            busy;
  logic            cdbreq;
  logic            cdbgrant;
  logic [3:0]      cdbtag;
  logic [7:0]      cdbval;
  logic [7:0]      cdbflag;
  logic [7:0]      cdbwbs;
  logic [7:0]      cdbrobid;
  logic            issueerr;

  int tests = 0;
  int fails = 0;

  fu_alu #(.MULCYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .issuevalid (issuevalid),
    .operand    (operand),
    .wbs        (wbs),
    .depvals    (depvals),
    .flag       (flag),
    .robid      (robid),
    .busy       (busy),
    .cdbreq     (cdbreq),
    .cdbgrant   (cdbgrant),
    .cdbtag     (cdbtag),
    .cdbval     (cdbval),
    .cdbflag    (cdbflag),
    .cdbwbs     (cdbwbs),
    .cdbrobid   (cdbrobid),
    .issueerr   (issueerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] val;
    logic [7:0] flg;
    int         lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int sx(input logic [7:0] x);
    return int'(x) - (x[7] ? 256 : 0);
  endfunction

  function automatic void model(input logic [7:0] op, a, b,
                                input logic cin,
                                output logic [7:0] v,
                                output logic [7:0] f);
    int r, sr;
    bit c, ov, ill;
    c = 0; ov = 0; ill = 0; sr = 0; r = 0;
    case (op)
      8'h00: begin
        r  = int'(a) + int'(b) + int'(cin);
        sr = sx(a) + sx(b) + int'(cin);
        c  = r > 255;
        ov = sr > 127 || sr < -128;
      end
      8'h01: begin
        r  = int'(a) - int'(b) - int'(cin);
        sr = sx(a) - sx(b) - int'(cin);
        c  = r < 0;
        ov = sr > 127 || sr < -128;
      end
      8'h02: r = int'(a & b);
      8'h03: r = int'(a | b);
      8'h04: r = int'(a ^ b);
      8'h05: r = int'(a) * (1 << b[2:0]);
      8'h06: r = int'(a) / (1 << b[2:0]);
      8'h07: begin
        r = int'(a) * int'(b);
        c = r > 255;
      end
      8'h08: r = int'(a);
      default: ill = 1;
    endcase
    v = r[7:0];
    f = 8'h00;
    f[0] = (v == 8'h00);
    f[1] = c;
    f[2] = v[7];
    f[3] = ov;
    f[7] = ill;
  endfunction

  // call at a negedge; returns at the negedge of cycle t+1
  task automatic drive_issue(input logic [7:0] op, a, b,
                             input logic cin,
                             input logic [7:0] rid, w);
    operand    = op;
    depvals[0] = a;
    depvals[1] = b;
    flag       = {7'b1010101, cin};
    robid      = rid;
    wbs        = w;
    issuevalid = 1'b1;
    @(negedge clk);
    issuevalid = 1'b0;
    operand    = 8'h00;
    depvals    = '0;
    flag       = 8'h00;
    robid      = 8'h00;
    wbs        = 8'h00;
  endtask

  task automatic wait_req(output int lat, output int idle_cycles);
    lat = 1;
    idle_cycles = 0;
    while (cdbreq !== 1'b1 && lat < 50) begin
      if (busy !== 1'b1) idle_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic grant_and_check(input string nm);
    cdbgrant = 1'b1;
    #1;
    chk({nm, " busy in grant"}, busy, 0);
    @(negedge clk);
    cdbgrant = 1'b0;
    chk({nm, " req after grant"}, cdbreq, 0);
    chk({nm, " val after grant"}, cdbval, 0);
  endtask

  task automatic run_one(input string nm,
                         input logic [7:0] op, a, b,
                         input logic cin,
                         input logic [7:0] rid, w,
                         input logic [7:0] ev, ef,
                         input int el, input int gd);
    int lat, idl;
    drive_issue(op, a, b, cin, rid, w);
    wait_req(lat, idl);
    chk({nm, " latency"}, lat, el);
    chk({nm, " busy drop"}, idl, 0);
    for (int k = 0; k < gd; k++) begin
      chk({nm, " held busy"}, busy, 1);
      chk({nm, " held val"}, cdbval, ev);
      @(negedge clk);
    end
    chk({nm, " val"}, cdbval, ev);
    chk({nm, " flag"}, cdbflag, ef);
    chk({nm, " tag"}, cdbtag, rid[3:0]);
    chk({nm, " robid"}, cdbrobid, rid);
    chk({nm, " wbs"}, cdbwbs, w);
    grant_and_check(nm);
  endtask

  initial begin
    int lat, idl, hits;
    logic [7:0] op, a, b, ev, ef;
    logic cin;

    vt[0]  = '{8'h00, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h0C, 1};
    vt[1]  = '{8'h01, 8'h05, 8'h05, 1'b0, 8'h00, 8'h01, 1};
    vt[2]  = '{8'h00, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h03, 1};
    vt[3]  = '{8'h00, 8'h10, 8'h20, 1'b1, 8'h31, 8'h00, 1};
    vt[4]  = '{8'h01, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h06, 1};
    vt[5]  = '{8'h01, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h08, 1};
    vt[6]  = '{8'h02, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1};
    vt[7]  = '{8'h03, 8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h04, 1};
    vt[8]  = '{8'h04, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h01, 1};
    vt[9]  = '{8'h05, 8'h81, 8'h09, 1'b0, 8'h02, 8'h00, 1};
    vt[10] = '{8'h06, 8'h80, 8'h07, 1'b0, 8'h01, 8'h00, 1};
    vt[11] = '{8'h07, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h04, 9};
    vt[12] = '{8'h07, 8'h10, 8'h10, 1'b0, 8'h00, 8'h03, 9};
    vt[13] = '{8'h08, 8'h9C, 8'h55, 1'b1, 8'h9C, 8'h04, 1};
    vt[14] = '{8'h3C, 8'h12, 8'h34, 1'b0, 8'h00, 8'h81, 1};
    vt[15] = '{8'h00, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h0C, 1};

    rst = 1'b1;
    issuevalid = 1'b0;
    cdbgrant = 1'b0;
    operand = 8'h00;
    wbs = 8'h00;
    depvals = '0;
    flag = 8'h00;
    robid = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset req", cdbreq, 0);
    chk("reset err", issueerr, 0);
    chk("reset val", cdbval, 0);
    chk("reset flag", cdbflag, 0);
    chk("reset tag", cdbtag, 0);
    rst = 1'b0;
    @(negedge clk);

    // grant with nothing pending has no effect
    cdbgrant = 1'b1;
    @(negedge clk);
    cdbgrant = 1'b0;
    chk("stray grant req", cdbreq, 0);
    chk("stray grant busy", busy, 0);

    for (int i = 0; i < 16; i++)
      run_one($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
              vt[i].cin, 8'(8'hA0 + i), 8'(8'h30 + i),
              vt[i].val, vt[i].flg, vt[i].lat, (i == 1) ? 3 : 0);

    // back-to-back: issue lands the cycle after grant
    drive_issue(8'h00, 8'h01, 8'h02, 1'b0, 8'h15, 8'h01);
    wait_req(lat, idl);
    cdbgrant = 1'b1;
    #1;
    chk("b2b busy drop", busy, 0);
    @(negedge clk);
    cdbgrant = 1'b0;
    drive_issue(8'h04, 8'h0F, 8'hFF, 1'b0, 8'h16, 8'h02);
    wait_req(lat, idl);
    chk("b2b latency", lat, 1);
    chk("b2b val", cdbval, 8'hF0);
    chk("b2b tag", cdbtag, 4'h6);
    chk("b2b err", issueerr, 0);
    grant_and_check("b2b");

    // issue during MUL at t+3 is dropped
    drive_issue(8'h07, 8'h0F, 8'h11, 1'b0, 8'h21, 8'h03);
    repeat (2) @(negedge clk);
    drive_issue(8'h00, 8'h01, 8'h01, 1'b0, 8'h22, 8'h04);
    wait_req(lat, idl);
    chk("midmul latency", lat, 6);
    chk("midmul val", cdbval, 8'hFF);
    chk("midmul flag", cdbflag, 8'h04);
    chk("midmul robid", cdbrobid, 8'h21);
    chk("midmul err", issueerr, 1);
    grant_and_check("midmul");
    chk("err sticky", issueerr, 1);

    // reset at t+4 of a MUL abandons it
    drive_issue(8'h07, 8'h03, 8'h05, 1'b0, 8'h31, 8'h05);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmul busy", busy, 0);
    chk("rstmul req", cdbreq, 0);
    chk("rstmul err", issueerr, 0);
    chk("rstmul val", cdbval, 0);
    chk("rstmul robid", cdbrobid, 0);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      if (cdbreq !== 1'b0) hits++;
      @(negedge clk);
    end
    chk("rstmul no bcast", hits, 0);

    // reset beats a simultaneous issue
    rst = 1'b1;
    drive_issue(8'h00, 8'h01, 8'h01, 1'b0, 8'h41, 8'h06);
    rst = 1'b0;
    chk("rst+issue busy", busy, 0);
    @(negedge clk);
    chk("rst+issue req", cdbreq, 0);

    for (int n = 0; n < 40; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                        : 8'($urandom_range(0, 9));
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      model(op, a, b, cin, ev, ef);
      run_one($sformatf("rnd%0d op%0h", n, op), op, a, b, cin,
              8'($urandom), 8'($urandom), ev, ef,
              (op == 8'h07) ? 9 : 1, $urandom_range(0, 2));
    end
    chk("final err", issueerr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
